// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes and the BRAM controller state encoding.
// Imported by the byte-mask decoder and the controller top.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_STALL,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/ahb_byte_mask.sv
// Little-endian byte-lane mask from HSIZE and HADDR[1:0].
// Also flags misaligned or oversized transfers.
module ahb_byte_mask
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       misaligned
);

    // Sizes above a word still enable every lane but are flagged.
    always_comb begin
        mask       = 4'b1111;
        misaligned = 1'b0;
        if (hsize == HSIZE_BYTE) begin
            mask = 4'b0001 << addr_lo;
        end else if (hsize == HSIZE_HALF) begin
            mask       = 4'b0011 << {addr_lo[1], 1'b0};
            misaligned = addr_lo[0];
        end else if (hsize == HSIZE_WORD) begin
            misaligned = |addr_lo;
        end else begin
            misaligned = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave driving a single-port byte-write BRAM.
// Define AHB_BRAM_ERR_EN for two-cycle ERROR on bad accesses.
module ahb_bram_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    output logic [3:0]            bram_we,
    input  logic [31:0]           bram_rdata
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              mask_q, mask_d;
    logic                    write_q, write_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_d;

    logic                    accept;
    logic                    bad;
    logic [3:0]              mask_w;
    logic                    misaligned_w;
    logic [ADDR_WIDTH-1:0]   haddr_w;

    assign accept  = HSEL & HTRANS[1] & HREADY;
    assign haddr_w = HADDR[ADDR_WIDTH+1:2];

    ahb_byte_mask u_mask (
        .hsize      (HSIZE),
        .addr_lo    (HADDR[1:0]),
        .mask       (mask_w),
        .misaligned (misaligned_w)
    );

`ifdef AHB_BRAM_ERR_EN
    logic hresp_q;
    assign bad   = misaligned_w;
    assign HRESP = hresp_q;

    // ERROR flag tracks the two ERR states.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) hresp_q <= HRESP_OKAY;
        else        hresp_q <= hresp_d;
    end

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
`else
    assign bad   = 1'b0;
    assign HRESP = HRESP_OKAY;

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0],
                           misaligned_w, hresp_d};
`endif

    // Next-state, phase registers and registered ready/resp.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        write_d = write_q;
        if (accept) begin
            addr_d  = haddr_w;
            mask_d  = mask_w;
            write_d = HWRITE;
        end
        case (state_q)
            ST_WR: begin
                if (!accept)     state_d = ST_IDLE;
                else if (bad)    state_d = ST_ERR1;
                else if (HWRITE) state_d = ST_WR;
                else             state_d = ST_RD_STALL;
            end
            ST_RD_STALL: state_d = ST_RD;
            ST_ERR1:     state_d = ST_ERR2;
            default: begin
                if (!accept)     state_d = ST_IDLE;
                else if (bad)    state_d = ST_ERR1;
                else if (HWRITE) state_d = ST_WR;
                else             state_d = ST_RD;
            end
        endcase
        hreadyout_d = !(state_d == ST_RD_STALL || state_d == ST_ERR1);
        hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2);
    end

    // State and phase registers, cleared asynchronously.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            mask_q      <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    // BRAM port: pending phase owns the port in WR/RD_STALL.
    always_comb begin
        bram_addr  = haddr_w;
        bram_we    = 4'b0000;
        bram_wdata = HWDATA;
        HRDATA     = 32'h0;
        if (state_q == ST_WR || state_q == ST_RD_STALL) begin
            bram_addr = addr_q;
        end
        if (state_q == ST_WR && write_q) begin
            bram_we = mask_q;
        end
        if (state_q == ST_RD) begin
            HRDATA = bram_rdata;
        end
    end

    assign HREADYOUT = hreadyout_q;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed cycle tables for the AHB BRAM controller.
// Includes a behavioural BRAM with 1-cycle registered read.
module tb_ahb_bram_ctrl;

    localparam int AW = 14;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;
    logic [3:0]    bram_we;
    logic [31:0]   bram_rdata = 32'h0;

    logic [31:0]   mem [0:63] = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HREADY     (HREADYOUT),
        .HWDATA     (HWDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_we    (bram_we),
        .bram_rdata (bram_rdata)
    );

    always @(posedge HCLK) begin
        for (int b = 0; b < 4; b++)
            if (bram_we[b])
                mem[bram_addr[5:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
        bram_rdata <= mem[bram_addr[5:0]];
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        resp;
        logic [3:0]  we;
        logic [AW-1:0] baddr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic sel, logic [1:0] tr, logic wr,
                                logic [2:0] sz, logic [31:0] a,
                                logic [31:0] wd, logic rdy, logic resp,
                                logic [3:0] we, logic [AW-1:0] ba,
                                logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz;
        v.addr = a; v.wdata = wd; v.rdy = rdy; v.resp = resp;
        v.we = we; v.baddr = ba; v.rdata = rd;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        HSEL   = v.sel;
        HTRANS = v.trans;
        HWRITE = v.wr;
        HSIZE  = v.size;
        HADDR  = v.addr;
        HWDATA = v.wdata;
    endtask

    task automatic run_table(string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge HCLK);
            drive(vq[i]);
            #2;
            check($sformatf("%s%0d.rdy", tag, i), {31'b0, HREADYOUT}, {31'b0, vq[i].rdy});
            check($sformatf("%s%0d.resp", tag, i), {31'b0, HRESP}, {31'b0, vq[i].resp});
            check($sformatf("%s%0d.we", tag, i), {28'b0, bram_we}, {28'b0, vq[i].we});
            check($sformatf("%s%0d.rdata", tag, i), HRDATA, vq[i].rdata);
            if (vq[i].we != 4'b0000)
                check($sformatf("%s%0d.baddr", tag, i),
                      {{(32-AW){1'b0}}, bram_addr}, {{(32-AW){1'b0}}, vq[i].baddr});
            check($sformatf("%s%0d.bwd", tag, i), bram_wdata, vq[i].wdata);
        end
        vq.delete();
    endtask

    localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    initial begin
        HRESET = 1'b1;
        drive(mk(0, I, 0, SW, 0, 0, 1, 0, 0, 0, 0));
        repeat (3) @(negedge HCLK);
        check("rst.rdy", {31'b0, HREADYOUT}, 32'd1);
        check("rst.resp", {31'b0, HRESP}, 32'd0);
        check("rst.we", {28'b0, bram_we}, 32'd0);
        check("rst.rdata", HRDATA, 32'd0);
        HRESET = 1'b0;

        // sel tr wr sz addr wdata | rdy resp we baddr rdata
        vq.push_back(mk(1, N, 1, SW, 32'h10, 0,            1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h10, 32'hDEADBEEF, 1, 0, 4'hF, 4, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h10, 0,            0, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, I, 0, SW, 32'h0,  0,            1, 0, 4'h0, 0, 32'hDEADBEEF));
        vq.push_back(mk(1, I, 0, SW, 32'h0,  0,            1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h10, 0,            1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, N, 1, SB, 32'h13, 0,            1, 0, 4'h0, 0, 32'hDEADBEEF));
        vq.push_back(mk(1, N, 0, SW, 32'h10, 32'hAA000000, 1, 0, 4'h8, 4, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h10, 0,            0, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, N, 1, SH, 32'h22, 0,            1, 0, 4'h0, 0, 32'hAAADBEEF));
        vq.push_back(mk(1, N, 0, SW, 32'h20, 32'h12340000, 1, 0, 4'hC, 8, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h20, 0,            0, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, N, 1, SW, 32'h0,  0,            1, 0, 4'h0, 0, 32'h12340000));
        vq.push_back(mk(1, N, 1, SW, 32'h4,  32'h11111111, 1, 0, 4'hF, 0, 0));
        vq.push_back(mk(1, N, 1, SW, 32'h8,  32'h22222222, 1, 0, 4'hF, 1, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h0,  32'h33333333, 1, 0, 4'hF, 2, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h0,  0,            0, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, S, 0, SW, 32'h4,  0,            1, 0, 4'h0, 0, 32'h11111111));
        vq.push_back(mk(1, S, 0, SW, 32'h8,  0,            1, 0, 4'h0, 0, 32'h22222222));
        vq.push_back(mk(1, I, 0, SW, 32'h0,  0,            1, 0, 4'h0, 0, 32'h33333333));
        vq.push_back(mk(0, N, 1, SW, 32'h0,  0,            1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, B, 1, SW, 32'h0,  32'hFFFFFFFF, 1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h0,  32'hFFFFFFFF, 1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, I, 0, SW, 32'h0,  0,            1, 0, 4'h0, 0, 32'h11111111));
        run_table("v");

        // Reset during a write data phase.
        @(negedge HCLK);
        drive(mk(1, N, 1, SW, 32'h40, 0, 1, 0, 0, 0, 0));
        @(negedge HCLK);
        drive(mk(1, I, 0, SW, 32'h0, 32'h5A5A5A5A, 1, 0, 0, 0, 0));
        #2;
        check("mid.we", {28'b0, bram_we}, 32'hF);
        #1 HRESET = 1'b1;
        #1;
        check("mid.rst.we", {28'b0, bram_we}, 32'h0);
        check("mid.rst.rdy", {31'b0, HREADYOUT}, 32'd1);
        check("mid.rst.rdata", HRDATA, 32'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        vq.push_back(mk(1, N, 0, SW, 32'h40, 0, 1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, I, 0, SW, 32'h0,  0, 1, 0, 4'h0, 0, 0));
        run_table("r");

`ifdef AHB_BRAM_ERR_EN
        vq.push_back(mk(1, N, 0, SW, 32'h2, 0,            1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, I, 0, SW, 32'h0, 0,            0, 1, 4'h0, 0, 0));
        vq.push_back(mk(1, I, 0, SW, 32'h0, 0,            1, 1, 4'h0, 0, 0));
        vq.push_back(mk(1, N, 1, SW, 32'h2, 0,            1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, I, 0, SW, 32'h0, 32'hBAD0BAD0, 0, 1, 4'h0, 0, 0));
        vq.push_back(mk(1, I, 0, SW, 32'h0, 0,            1, 1, 4'h0, 0, 0));
        vq.push_back(mk(1, N, 0, SW, 32'h0, 0,            1, 0, 4'h0, 0, 0));
        vq.push_back(mk(1, I, 0, SW, 32'h0, 0,            1, 0, 4'h0, 0, 32'h11111111));
        run_table("e");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
